bypass_fifo: RTL
================

Name: bypass_fifo

Overview:
- Parametrised multi-entry successor to the single-entry bypass buffer: a DEPTH-entry FIFO with optional combinational empty-bypass, upstream backpressure, occupancy count and synchronous flush.
- Sits between pipeline stages, e.g. fetch→decode instruction queue or the LSU response path, where the producer may run ahead of the consumer by up to DEPTH items.
- Consumer-side semantics match the existing buffer: next_en is a take-strobe, qualified by next_valid.

Parameters:
- WIDTH, 8, payload width in bits.
- DEPTH, 4, storage entries; power of two, ≥2.
- BYPASS, 1; 1 = empty FIFO forwards prev_data combinationally, 0 = minimum one-cycle latency through storage.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset.
- flush  input  1  synchronous discard of all stored entries.
- prev_valid  input  1  producer offers prev_data.
- prev_data  input  WIDTH  producer payload.
- prev_ready  output  1  FIFO can accept this cycle.
- next_en  input  1  consumer takes next_data this cycle (ignored when next_valid=0).
- next_valid  output  1  next_data is valid.
- next_data  output  WIDTH  head payload.
- count  output  $clog2(DEPTH+1)  stored entries (bypassed item not counted).

Behaviour:
- Reset (rst=0 at posedge): rd_ptr=wr_ptr=0, count=0, next_valid=0, prev_ready=1 after reset. Storage array is not reset.
- Pointers: $clog2(DEPTH) bits, natural wrap at DEPTH. count is a separate register (no extra pointer bit).
- empty = (count==0); full = (count==DEPTH).
- prev_ready = !full & !flush. It is registered-state-derived only, with no combinational path from next_en.
- accept = prev_valid & prev_ready.
- Head selection:
  - count>0: next_valid=1, next_data=mem[rd_ptr].
  - count==0, BYPASS=1: next_valid = prev_valid & !flush, next_data=prev_data.
  - count==0, BYPASS=0: next_valid=0; next_data is don't-care, driven as mem[rd_ptr].
- take = next_en & next_valid.
- bypass_hit = BYPASS & empty & accept & take. The item passes through and is neither written nor counted.
- push = accept & !bypass_hit: mem[wr_ptr] ← prev_data, wr_ptr+1.
- pop = take & !empty: rd_ptr+1.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when full: push is blocked by prev_ready=0, so a pop-only cycle follows. Full-throughput refill needs one bubble; this is accepted.
- Simultaneous push and pop at count=1: the head leaves, the new item is stored, count stays 1.
- flush=1 (synchronous, priority over push/pop): next cycle rd_ptr=wr_ptr=0, count=0. During the flush cycle, next_valid=0 and prev_ready=0, so no transfer occurs.
- rst=0 overrides flush. Reset mid-stream drops all entries with no partial output.
- Latency:
  - BYPASS=1 and empty: 0 cycles.
  - Otherwise an item appears at the head the cycle after its push, behind all older entries.
- Order is strictly FIFO. No entry is ever duplicated or dropped except by flush or reset.
- Assertions (sim only): count≤DEPTH; no push when full; no pop when empty.

Decomposition:
- No new shared package typedefs are needed. DEPTH power-of-two check goes in an elaboration-time assertion.
- Pointer width is a localparam.
- Reuse the existing ffenr/ffen flop gadgets for count and pointers.
- One natural sub-module: fifo_mem (WIDTH×DEPTH register array, 1 write port, 1 asynchronous read port).

Test Plan:
- Reset then BYPASS=1, empty, prev_valid=1, prev_data=8'hA5, next_en=1 same cycle → next_valid=1, next_data=8'hA5 that cycle; count stays 0; prev_ready=1.
- DEPTH=4, next_en=0, push 8'h01..8'h04 on 4 cycles → count 1,2,3,4; prev_ready=0 after the 4th; a 5th offer 8'h05 is not accepted.
- From full, next_en=1 for 4 cycles → next_data 01,02,03,04 in order; count 3,2,1,0; prev_ready=1 after the first pop.
- count=1 (head 8'h10), push 8'h11 and next_en=1 the same cycle → 8'h10 leaves, count stays 1, next cycle next_data=8'h11.
- count=3 with wr_ptr wrapped (push 6, pop 3 beforehand), flush=1 with prev_valid=1 → next_valid=0 and prev_ready=0 that cycle; next cycle count=0; the flushed offer is not stored.
- BYPASS=0, empty, push 8'h7E with next_en=1 → next_valid=0 that cycle, next cycle next_valid=1 with 8'h7E. Then rst=0 mid-stream → count=0, next_valid=0.

Source files
------------

// File: rtl/bypass_fifo_pkg.sv
// bypass_fifo_pkg: shared helpers for the bypass FIFO slice.
//   ptr_bits - pointer width for a given depth (never below 1 bit)
//   is_pow2  - true when depth is a power of two
package bypass_fifo_pkg;

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bypass_fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register array, one synchronous write port, one asynchronous read port.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write payload
//   raddr - read address
//   rdata - combinational read payload
module fifo_mem
    import bypass_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ptr_bits(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [ptr_bits(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; validity is tracked by the count.
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/bypass_fifo.sv
// bypass_fifo: DEPTH-entry FIFO with optional combinational empty-bypass, backpressure, count and flush.
//   clk        - rising-edge clock
//   rst        - synchronous active-low reset
//   flush      - synchronous discard of all stored entries
//   prev_valid - producer offers prev_data
//   prev_data  - producer payload
//   prev_ready - FIFO can accept this cycle
//   next_en    - consumer take strobe (qualified by next_valid)
//   next_valid - next_data is valid
//   next_data  - head payload
//   count      - stored entries (a bypassed item is never counted)
module bypass_fifo
    import bypass_fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       prev_valid,
    input  logic [WIDTH-1:0]           prev_data,
    output logic                       prev_ready,
    input  logic                       next_en,
    output logic                       next_valid,
    output logic [WIDTH-1:0]           next_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("bypass_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [WIDTH-1:0] head;
    logic             empty, full, accept, take, bypass_hit, push, pop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    // Depends only on registered state and flush, never on next_en.
    assign prev_ready = !full && !flush;
    assign accept     = prev_valid && prev_ready;
    assign next_valid = flush ? 1'b0 : !empty ? 1'b1 : (BYPASS && prev_valid);
    assign next_data  = (!empty || !BYPASS) ? head : prev_data;
    assign take       = next_en && next_valid;
    // A bypassed item goes straight through and never touches storage.
    assign bypass_hit = BYPASS && empty && accept && take;
    assign push       = accept && !bypass_hit;
    assign pop        = take && !empty;

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (prev_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk)
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
        end

    always_ff @(posedge clk)
        if (rst) begin
            assert (count <= CW'(DEPTH));
            assert (!(push && full));
            assert (!(pop && empty));
        end

endmodule
